// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding fetches to instruction memory
// and presents registered PC/instruction pairs to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_addr_if,
    output logic [31:0] fetched_inst_if,
    output logic        inst_valid_if,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        misal_q, misal_d;
    logic [31:0] skid_addr_q, skid_addr_d;
    logic [31:0] skid_data_q, skid_data_d;

    logic [31:0] target;
    logic [31:0] pc_next;

    assign target  = {redirect_pc_i[31:2], 2'b00};
    assign pc_next = pc_q + PC_STEP;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        pc_out_d    = pc_out_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        misal_d     = 1'b0;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;

        if (redirect_i) begin
            pc_out_d    = 32'h0;
            inst_d      = BUBBLE_INST;
            valid_d     = 1'b0;
            skid_addr_d = 32'h0;
            skid_data_d = 32'h0;
            pc_d        = target;
            misal_d     = |redirect_pc_i[1:0];
            // An outstanding request cannot be withdrawn; its response must be drained first.
            if ((state_q == StReq || state_q == StDrop) && !imem_rvalid_i) begin
                state_d = StDrop;
            end else begin
                state_d = StReq;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = StReq;
                end
                StReq: begin
                    if (imem_rvalid_i) begin
                        if (stall_i) begin
                            skid_addr_d = addr_q;
                            skid_data_d = imem_rdata_i;
                            req_d       = 1'b0;
                            state_d     = StHold;
                        end else begin
                            pc_out_d = addr_q;
                            inst_d   = imem_rdata_i;
                            valid_d  = 1'b1;
                            pc_d     = pc_next;
                            addr_d   = pc_next;
                        end
                    end
                end
                StHold: begin
                    if (!stall_i) begin
                        pc_out_d = skid_addr_q;
                        inst_d   = skid_data_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_next;
                        addr_d   = pc_next;
                        req_d    = 1'b1;
                        state_d  = StReq;
                    end
                end
                StDrop: begin
                    if (imem_rvalid_i) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= 32'h0;
            pc_out_q    <= 32'h0;
            inst_q      <= BUBBLE_INST;
            valid_q     <= 1'b0;
            misal_q     <= 1'b0;
            skid_addr_q <= 32'h0;
            skid_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            pc_out_q    <= pc_out_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            misal_q     <= misal_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign imem_req_o      = req_q;
    assign imem_addr_o     = addr_q;
    assign pc_addr_if      = pc_out_q;
    assign fetched_inst_if = inst_q;
    assign inst_valid_if   = valid_q;
    assign misaligned_o    = misal_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency instruction memory model.
module tb_if_fetch_unit;

    logic        sys_clk;
    logic        rstn;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] pc_addr_if;
    logic [31:0] fetched_inst_if;
    logic        inst_valid_if;
    logic        misaligned_o;

    int n_chk  = 0;
    int n_pass = 0;
    int mem_lat = 1;
    int mem_cnt = 0;

    if_fetch_unit dut (
        .sys_clk        (sys_clk),
        .rstn           (rstn),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rvalid_i  (mem_rvalid),
        .imem_rdata_i   (mem_rdata),
        .pc_addr_if     (pc_addr_if),
        .fetched_inst_if(fetched_inst_if),
        .inst_valid_if  (inst_valid_if),
        .misaligned_o   (misaligned_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Response is offered mem_lat cycles after the request appears and lasts one edge.
    always @(negedge sys_clk) begin
        if (!rstn) begin
            mem_rvalid = 1'b0;
            mem_cnt    = 0;
        end else begin
            if (mem_rvalid) begin
                mem_rvalid = 1'b0;
                mem_cnt    = 0;
            end
            if (imem_req_o) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_data(imem_addr_o);
                end
            end
        end
    end

    task automatic cycle();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_rvalid(input string name);
        for (int i = 0; i < 10; i++) begin
            if (mem_rvalid) break;
            cycle();
        end
        n_chk++;
        if (mem_rvalid !== 1'b1) $display("FAIL %s: rvalid got %b want 1", name, mem_rvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (imem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req_o);
        else n_pass++;
        n_chk++; if (imem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr_o);
        else n_pass++;
        n_chk++; if (inst_valid_if !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid_if);
        else n_pass++;
        n_chk++; if (fetched_inst_if !== 32'h0)
            $display("FAIL rst_inst: got %h want 0", fetched_inst_if);
        else n_pass++;
        n_chk++; if (misaligned_o !== 1'b0) $display("FAIL rst_misal: got %b want 0", misaligned_o);
        else n_pass++;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    task automatic test_sequential();
        cycle();
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
            $display("FAIL seq_first_req: got %b/%h want 1/0", imem_req_o, imem_addr_o);
        else n_pass++;
        n_chk++; if (inst_valid_if !== 1'b0) $display("FAIL seq_valid0: got %b want 0", inst_valid_if);
        else n_pass++;
        cycle();
        n_chk++; if (pc_addr_if !== 32'h0 || fetched_inst_if !== 32'h1357_9BDF || !inst_valid_if)
            $display("FAIL seq_out0: got %h/%h/%b want 0/13579bdf/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
        n_chk++; if (imem_addr_o !== 32'h4) $display("FAIL seq_addr4: got %h want 4", imem_addr_o);
        else n_pass++;
        cycle();
        n_chk++; if (pc_addr_if !== 32'h4 || fetched_inst_if !== 32'h1357_9BDB || !inst_valid_if)
            $display("FAIL seq_out1: got %h/%h/%b want 4/13579bdb/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
        n_chk++; if (imem_addr_o !== 32'h8) $display("FAIL seq_addr8: got %h want 8", imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_chk++; if (pc_addr_if !== 32'h4 || fetched_inst_if !== 32'h1357_9BDB || !inst_valid_if)
                $display("FAIL stall_hold%0d: got %h/%h/%b want 4/13579bdb/1",
                         i, pc_addr_if, fetched_inst_if, inst_valid_if);
            else n_pass++;
            n_chk++; if (imem_req_o !== 1'b0)
                $display("FAIL stall_req%0d: got %b want 0", i, imem_req_o);
            else n_pass++;
        end
        mem_lat = 3;
        stall_i = 1'b0;
        cycle();
        n_chk++; if (pc_addr_if !== 32'h8 || fetched_inst_if !== 32'h1357_9BD7 || !inst_valid_if)
            $display("FAIL stall_release: got %h/%h/%b want 8/13579bd7/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC)
            $display("FAIL stall_next_req: got %b/%h want 1/c", imem_req_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_redirect_drop();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        cycle();
        redirect_i = 1'b0;
        n_chk++; if (inst_valid_if !== 1'b0 || fetched_inst_if !== 32'h0 || pc_addr_if !== 32'h0)
            $display("FAIL drop_flush: got %b/%h/%h want 0/0/0",
                     inst_valid_if, fetched_inst_if, pc_addr_if);
        else n_pass++;
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC)
            $display("FAIL drop_stale_req: got %b/%h want 1/c", imem_req_o, imem_addr_o);
        else n_pass++;
        wait_rvalid("drop_stale_rvalid");
        cycle();
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || inst_valid_if !== 1'b0)
            $display("FAIL drop_target_req: got %b/%h/%b want 1/100/0",
                     imem_req_o, imem_addr_o, inst_valid_if);
        else n_pass++;
        wait_rvalid("drop_target_rvalid");
        cycle();
        n_chk++; if (pc_addr_if !== 32'h100 || fetched_inst_if !== 32'h1357_9ADF || !inst_valid_if)
            $display("FAIL drop_out: got %h/%h/%b want 100/13579adf/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
        n_chk++; if (imem_addr_o !== 32'h104) $display("FAIL drop_next: got %h want 104", imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_redirect_rvalid_stall();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h10;
        cycle();
        redirect_i = 1'b0;
        wait_rvalid("rvs_stale_rvalid");
        cycle();
        n_chk++; if (imem_addr_o !== 32'h10) $display("FAIL rvs_req10: got %h want 10", imem_addr_o);
        else n_pass++;
        wait_rvalid("rvs_rvalid10");
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        stall_i       = 1'b1;
        cycle();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200)
            $display("FAIL rvs_target: got %b/%h want 1/200", imem_req_o, imem_addr_o);
        else n_pass++;
        n_chk++; if (inst_valid_if !== 1'b0 || pc_addr_if !== 32'h0 || fetched_inst_if !== 32'h0)
            $display("FAIL rvs_dropped: got %b/%h/%h want 0/0/0",
                     inst_valid_if, pc_addr_if, fetched_inst_if);
        else n_pass++;
        n_chk++; if (misaligned_o !== 1'b1) $display("FAIL misal_pulse: got %b want 1", misaligned_o);
        else n_pass++;
        cycle();
        n_chk++; if (misaligned_o !== 1'b0) $display("FAIL misal_clear: got %b want 0", misaligned_o);
        else n_pass++;
        wait_rvalid("rvs_rvalid200");
        cycle();
        n_chk++; if (pc_addr_if !== 32'h200 || fetched_inst_if !== 32'h1357_99DF || !inst_valid_if)
            $display("FAIL rvs_out: got %h/%h/%b want 200/135799df/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
    endtask

    task automatic test_wrap();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        redirect_i = 1'b0;
        wait_rvalid("wrap_stale_rvalid");
        cycle();
        n_chk++; if (imem_addr_o !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req: got %h want fffffffc", imem_addr_o);
        else n_pass++;
        wait_rvalid("wrap_rvalid");
        cycle();
        n_chk++; if (pc_addr_if !== 32'hFFFF_FFFC || fetched_inst_if !== 32'hECA8_6423)
            $display("FAIL wrap_out: got %h/%h want fffffffc/eca86423", pc_addr_if, fetched_inst_if);
        else n_pass++;
        n_chk++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1)
            $display("FAIL wrap_next: got %h/%b want 0/1", imem_addr_o, imem_req_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drop();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        cycle();
        redirect_i = 1'b0;
        cycle();
        rstn = 1'b0;
        #1;
        n_chk++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0)
            $display("FAIL arst_req: got %b/%h want 0/0", imem_req_o, imem_addr_o);
        else n_pass++;
        n_chk++; if (inst_valid_if !== 1'b0 || pc_addr_if !== 32'h0 || fetched_inst_if !== 32'h0)
            $display("FAIL arst_out: got %b/%h/%h want 0/0/0",
                     inst_valid_if, pc_addr_if, fetched_inst_if);
        else n_pass++;
        cycle();
        rstn = 1'b1;
        cycle();
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
            $display("FAIL arst_first_req: got %b/%h want 1/0", imem_req_o, imem_addr_o);
        else n_pass++;
        wait_rvalid("arst_rvalid");
        cycle();
        n_chk++; if (pc_addr_if !== 32'h0 || fetched_inst_if !== 32'h1357_9BDF || !inst_valid_if)
            $display("FAIL arst_out0: got %h/%h/%b want 0/13579bdf/1",
                     pc_addr_if, fetched_inst_if, inst_valid_if);
        else n_pass++;
    endtask

    initial begin
        rstn          = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_redirect_rvalid_stall();
        test_wrap();
        test_reset_mid_drop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
